// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops PS/2 set-2 scan-code bytes from the receive FIFO,
// folds the E0/F0/E1 prefixes into single key events and turns mapped keys
// into one-cycle game commands.
//
// Handshake: fifo_rd is a single-cycle pop request raised only while the
// FIFO reports non-empty; the popped byte is taken from fifo_data on the
// following cycle. key_valid, cmd_valid and err are one-cycle strobes with
// no back-pressure; key_code/key_ext/key_brk and cmd hold between strobes.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYC = 2500000,
  parameter bit REPEAT_EN   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic [7:0] held,
  output logic       err,
  output logic       dbg_state
);

  // Fetch FSM: IDLE waits for a byte, FETCH is the cycle the popped byte
  // is visible on fifo_data.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_e;

  // The timeout fires on the run cycle where the counter would reach
  // TIMEOUT_CYC-1, so the err strobe appears after TIMEOUT_CYC-1 idle cycles.
  localparam logic [21:0] TO_LAST = 22'(TIMEOUT_CYC - 2);

  state_e      state;
  state_e      state_nxt;

  logic        ext_f;
  logic        brk_f;
  logic [2:0]  skip_cnt;
  logic [21:0] to_cnt;

  logic        ctx_active;
  logic        to_run;
  logic        to_fire;
  logic        is_fetch;

  logic        byte_skip;
  logic        byte_e1;
  logic        byte_e0;
  logic        byte_f0;
  logic        byte_junk;
  logic        byte_event;

  logic        map_hit;
  logic [2:0]  map_idx;
  logic        issue_cmd;

  // Scan-code to command map; the extended bit has to match exactly, so
  // keypad codes without E0 fall through as unmapped.
  function automatic logic [3:0] map_key(input logic [7:0] code, input logic ext);
    logic [3:0] r;
    r = 4'b0000;
    if (ext) begin
      case (code)
        8'h6B:   r = {1'b1, 3'd0};
        8'h74:   r = {1'b1, 3'd1};
        8'h75:   r = {1'b1, 3'd2};
        8'h72:   r = {1'b1, 3'd3};
        default: r = 4'b0000;
      endcase
    end else begin
      case (code)
        8'h29:   r = {1'b1, 3'd4};
        8'h4D:   r = {1'b1, 3'd5};
        8'h5A:   r = {1'b1, 3'd6};
        8'h76:   r = {1'b1, 3'd7};
        default: r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  // FSM state register; reset mid-FETCH drops the byte already popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: pop whenever idle and a byte is waiting, parse next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: the pop request and the debug view of the state.
  always_comb begin
    fifo_rd   = 1'b0;
    dbg_state = state;
    if (state == S_IDLE && !fifo_empty) begin
      fifo_rd = 1'b1;
    end
  end

  // Byte classification in priority order, plus key lookup and command gating.
  always_comb begin
    is_fetch   = (state == S_FETCH);
    byte_skip  = (skip_cnt != 3'd0);
    byte_e1    = !byte_skip && (fifo_data == 8'hE1);
    byte_e0    = !byte_skip && (fifo_data == 8'hE0);
    byte_f0    = !byte_skip && (fifo_data == 8'hF0);
    byte_junk  = !byte_skip && ((fifo_data == 8'h00) || (fifo_data == 8'hAA) ||
                                (fifo_data == 8'hEE) || (fifo_data == 8'hFA) ||
                                (fifo_data == 8'hFE) || (fifo_data == 8'hFF));
    byte_event = !byte_skip && !byte_e1 && !byte_e0 && !byte_f0 && !byte_junk;
    {map_hit, map_idx} = map_key(fifo_data, ext_f);
    issue_cmd  = is_fetch && byte_event && map_hit && !brk_f &&
                 (!held[map_idx] || REPEAT_EN);
    ctx_active = ext_f || brk_f || (skip_cnt != 3'd0);
    to_run     = ctx_active && (state == S_IDLE) && fifo_empty;
    to_fire    = to_run && (to_cnt == TO_LAST);
  end

  // Prefix/skip context and its idle timeout; a fetched byte always beats
  // the timeout because the counter only runs in IDLE with the FIFO empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_f    <= 1'b0;
      brk_f    <= 1'b0;
      skip_cnt <= 3'd0;
      to_cnt   <= 22'd0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (is_fetch) begin
        to_cnt <= 22'd0;
        if (byte_skip) begin
          skip_cnt <= skip_cnt - 3'd1;
        end else if (byte_e1) begin
          skip_cnt <= 3'd7;
          ext_f    <= 1'b0;
          brk_f    <= 1'b0;
        end else if (byte_e0) begin
          ext_f <= 1'b1;
        end else if (byte_f0) begin
          brk_f <= 1'b1;
        end else begin
          // Junk bytes and completed events both leave a clean context.
          ext_f <= 1'b0;
          brk_f <= 1'b0;
        end
      end else if (to_fire) begin
        ext_f    <= 1'b0;
        brk_f    <= 1'b0;
        skip_cnt <= 3'd0;
        to_cnt   <= 22'd0;
        err      <= 1'b1;
      end else if (to_run) begin
        to_cnt <= to_cnt + 22'd1;
      end
    end
  end

  // Key event and command outputs; values hold until the next strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_brk   <= 1'b0;
      key_valid <= 1'b0;
      cmd       <= 3'd0;
      cmd_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      cmd_valid <= 1'b0;
      if (is_fetch && byte_event) begin
        key_code  <= fifo_data;
        key_ext   <= ext_f;
        key_brk   <= brk_f;
        key_valid <= 1'b1;
      end
      if (issue_cmd) begin
        cmd       <= map_idx;
        cmd_valid <= 1'b1;
      end
    end
  end

  // Held-key bitmap; only a mapped break or reset clears a bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held <= 8'h00;
    end else if (is_fetch && byte_event && map_hit) begin
      held[map_idx] <= !brk_f;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: two instances (no repeat / repeat)
// each fed from a small byte FIFO model.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- clock / reset ----------------
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FIFO models ----------------
  logic [7:0] mem_a [256];
  logic [7:0] wr_a = 8'd0;
  logic [7:0] rd_a = 8'd0;
  logic [7:0] data_a = 8'd0;
  logic       empty_a;
  logic       pop_a;

  logic [7:0] mem_b [256];
  logic [7:0] wr_b = 8'd0;
  logic [7:0] rd_b = 8'd0;
  logic [7:0] data_b = 8'd0;
  logic       empty_b;
  logic       pop_b;

  assign empty_a = (wr_a == rd_a);
  assign empty_b = (wr_b == rd_b);

  always @(posedge clk) begin
    if (pop_a && !empty_a) begin
      data_a <= mem_a[rd_a];
      rd_a   <= rd_a + 8'd1;
    end
    if (pop_b && !empty_b) begin
      data_b <= mem_b[rd_b];
      rd_b   <= rd_b + 8'd1;
    end
  end

  // ---------------- DUTs ----------------
  logic [7:0] key_code, r_key_code;
  logic       key_ext, key_brk, key_valid, cmd_valid, err, dbg_state;
  logic       r_key_ext, r_key_brk, r_key_valid, r_cmd_valid, r_err, r_dbg_state;
  logic [2:0] cmd, r_cmd;
  logic [7:0] held, r_held;

  ps2_key_decoder #(.TIMEOUT_CYC(100), .REPEAT_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_data(data_a), .fifo_rd(pop_a),
    .key_code(key_code), .key_ext(key_ext), .key_brk(key_brk), .key_valid(key_valid),
    .cmd(cmd), .cmd_valid(cmd_valid), .held(held), .err(err), .dbg_state(dbg_state)
  );

  ps2_key_decoder #(.TIMEOUT_CYC(100), .REPEAT_EN(1'b1)) dut_r (
    .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_data(data_b), .fifo_rd(pop_b),
    .key_code(r_key_code), .key_ext(r_key_ext), .key_brk(r_key_brk), .key_valid(r_key_valid),
    .cmd(r_cmd), .cmd_valid(r_cmd_valid), .held(r_held), .err(r_err), .dbg_state(r_dbg_state)
  );

  // ---------------- strobe monitor ----------------
  int kv_cnt = 0, cv_cnt = 0, er_cnt = 0, r_kv_cnt = 0, r_cv_cnt = 0;
  int kv_cyc = 0, cv_cyc = 0, er_cyc = 0, rd_cyc = 0;
  int rd_q[$];

  always @(negedge clk) begin
    if (pop_a) begin
      rd_cyc <= cyc;
      rd_q.push_back(cyc);
    end
    if (key_valid) begin
      kv_cnt <= kv_cnt + 1;
      kv_cyc <= cyc;
    end
    if (cmd_valid) begin
      cv_cnt <= cv_cnt + 1;
      cv_cyc <= cyc;
    end
    if (err) begin
      er_cnt <= er_cnt + 1;
      er_cyc <= cyc;
    end
    if (r_key_valid) r_kv_cnt <= r_kv_cnt + 1;
    if (r_cmd_valid) r_cv_cnt <= r_cv_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic push_a(input logic [7:0] b);
    mem_a[wr_a] = b;
    wr_a = wr_a + 8'd1;
  endtask

  task automatic push_b(input logic [7:0] b);
    mem_b[wr_b] = b;
    wr_b = wr_b + 8'd1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    settle(3);
    checks++;
    if ({pop_a, key_valid, cmd_valid, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000", {pop_a, key_valid, cmd_valid, err});
    end
    checks++;
    if ({key_code, key_ext, key_brk, cmd} !== 13'h0) begin
      errors++;
      $display("FAIL reset_key got %h/%b/%b/%0d want 00/0/0/0", key_code, key_ext, key_brk, cmd);
    end
    checks++;
    if (held !== 8'h00 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_held got held=%h st=%b want 00/0", held, dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    settle(2);
  endtask

  task automatic test_single_make;
    int kv0, cv0;
    kv0 = kv_cnt; cv0 = cv_cnt;
    @(negedge clk);
    push_a(8'h29);
    settle(10);
    checks++;
    if (kv_cnt - kv0 !== 1 || kv_cyc - rd_cyc !== 2) begin
      errors++;
      $display("FAIL make_latency got n=%0d lat=%0d want 1/2", kv_cnt - kv0, kv_cyc - rd_cyc);
    end
    checks++;
    if ({key_code, key_ext, key_brk} !== {8'h29, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL make_key got %h/%b/%b want 29/0/0", key_code, key_ext, key_brk);
    end
    checks++;
    if (cv_cnt - cv0 !== 1 || cv_cyc !== kv_cyc || cmd !== 3'd4) begin
      errors++;
      $display("FAIL make_cmd got n=%0d cmd=%0d want 1/4", cv_cnt - cv0, cmd);
    end
    checks++;
    if (held !== 8'h10) begin
      errors++;
      $display("FAIL make_held got %h want 10", held);
    end
    // release so later tests start with hard drop not held
    kv0 = kv_cnt; cv0 = cv_cnt;
    @(negedge clk);
    push_a(8'hF0); push_a(8'h29);
    settle(12);
    checks++;
    if (kv_cnt - kv0 !== 1 || key_brk !== 1'b1 || cv_cnt - cv0 !== 0 || held !== 8'h00) begin
      errors++;
      $display("FAIL break_29 got n=%0d brk=%b cmds=%0d held=%h want 1/1/0/00",
               kv_cnt - kv0, key_brk, cv_cnt - cv0, held);
    end
  endtask

  task automatic test_ext_make_break;
    int kv0, cv0;
    kv0 = kv_cnt; cv0 = cv_cnt;
    @(negedge clk);
    push_a(8'hE0); push_a(8'h6B);
    settle(12);
    checks++;
    if ({key_code, key_ext, key_brk} !== {8'h6B, 1'b1, 1'b0} || kv_cnt - kv0 !== 1) begin
      errors++;
      $display("FAIL ext_make got %h/%b/%b n=%0d want 6b/1/0/1", key_code, key_ext, key_brk, kv_cnt - kv0);
    end
    checks++;
    if (cv_cnt - cv0 !== 1 || cmd !== 3'd0 || held !== 8'h01) begin
      errors++;
      $display("FAIL ext_make_cmd got n=%0d cmd=%0d held=%h want 1/0/01", cv_cnt - cv0, cmd, held);
    end
    kv0 = kv_cnt; cv0 = cv_cnt;
    @(negedge clk);
    push_a(8'hE0); push_a(8'hF0); push_a(8'h6B);
    settle(14);
    checks++;
    if ({key_code, key_ext, key_brk} !== {8'h6B, 1'b1, 1'b1} || kv_cnt - kv0 !== 1) begin
      errors++;
      $display("FAIL ext_break got %h/%b/%b n=%0d want 6b/1/1/1", key_code, key_ext, key_brk, kv_cnt - kv0);
    end
    checks++;
    if (cv_cnt - cv0 !== 0 || held !== 8'h00) begin
      errors++;
      $display("FAIL ext_break_cmd got n=%0d held=%h want 0/00", cv_cnt - cv0, held);
    end
  endtask

  task automatic test_repeat;
    int kv0, cv0, rk0, rc0;
    kv0 = kv_cnt; cv0 = cv_cnt; rk0 = r_kv_cnt; rc0 = r_cv_cnt;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      push_a(8'h29);
      push_b(8'h29);
    end
    settle(16);
    checks++;
    if (kv_cnt - kv0 !== 3 || cv_cnt - cv0 !== 1) begin
      errors++;
      $display("FAIL repeat_off got keys=%0d cmds=%0d want 3/1", kv_cnt - kv0, cv_cnt - cv0);
    end
    checks++;
    if (r_kv_cnt - rk0 !== 3 || r_cv_cnt - rc0 !== 3 || r_cmd !== 3'd4) begin
      errors++;
      $display("FAIL repeat_on got keys=%0d cmds=%0d cmd=%0d want 3/3/4", r_kv_cnt - rk0, r_cv_cnt - rc0, r_cmd);
    end
  endtask

  task automatic test_pause_seq;
    int kv0, cv0;
    logic [7:0] seq [9];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h5A};
    kv0 = kv_cnt; cv0 = cv_cnt;
    @(negedge clk);
    for (int i = 0; i < 8; i++) push_a(seq[i]);
    settle(24);
    checks++;
    if (kv_cnt - kv0 !== 0 || cv_cnt - cv0 !== 0) begin
      errors++;
      $display("FAIL pause_swallow got keys=%0d cmds=%0d want 0/0", kv_cnt - kv0, cv_cnt - cv0);
    end
    @(negedge clk);
    push_a(seq[8]);
    settle(8);
    checks++;
    if (kv_cnt - kv0 !== 1 || {key_code, key_ext, key_brk} !== {8'h5A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pause_next_key got n=%0d %h/%b/%b want 1 5a/0/0", kv_cnt - kv0, key_code, key_ext, key_brk);
    end
    checks++;
    if (cv_cnt - cv0 !== 1 || cmd !== 3'd6 || held !== 8'h50) begin
      errors++;
      $display("FAIL pause_next_cmd got n=%0d cmd=%0d held=%h want 1/6/50", cv_cnt - cv0, cmd, held);
    end
  endtask

  task automatic test_timeout;
    int kv0, cv0, er0, rd0;
    kv0 = kv_cnt; cv0 = cv_cnt; er0 = er_cnt;
    @(negedge clk);
    push_a(8'hE0);
    settle(2);
    rd0 = rd_cyc;
    settle(250);
    // pop in cycle N, FETCH N+1, 99 idle cycles N+2..N+100, strobe in N+101
    checks++;
    if (er_cnt - er0 !== 1) begin
      errors++;
      $display("FAIL timeout_count got %0d want 1", er_cnt - er0);
    end
    checks++;
    if (er_cyc - rd0 !== 101) begin
      errors++;
      $display("FAIL timeout_delay got %0d want 101", er_cyc - rd0);
    end
    checks++;
    if (held !== 8'h50) begin
      errors++;
      $display("FAIL timeout_held got %h want 50", held);
    end
    @(negedge clk);
    push_a(8'h75);
    settle(8);
    checks++;
    if (kv_cnt - kv0 !== 1 || {key_code, key_ext} !== {8'h75, 1'b0} || cv_cnt - cv0 !== 0) begin
      errors++;
      $display("FAIL timeout_ctx got n=%0d %h/%b cmds=%0d want 1 75/0 0",
               kv_cnt - kv0, key_code, key_ext, cv_cnt - cv0);
    end
  endtask

  task automatic test_back_to_back;
    int kv0, cv0, er0, n0;
    kv0 = kv_cnt; cv0 = cv_cnt; er0 = er_cnt; n0 = rd_q.size();
    @(negedge clk);
    push_a(8'hE0); push_a(8'h74); push_a(8'hE0);
    settle(20);
    checks++;
    if (rd_q.size() - n0 !== 3) begin
      errors++;
      $display("FAIL b2b_pops got %0d want 3", rd_q.size() - n0);
    end else begin
      checks++;
      if (rd_q[n0 + 1] - rd_q[n0] !== 2 || rd_q[n0 + 2] - rd_q[n0 + 1] !== 2) begin
        errors++;
        $display("FAIL b2b_pattern got gaps %0d,%0d want 2,2",
                 rd_q[n0 + 1] - rd_q[n0], rd_q[n0 + 2] - rd_q[n0 + 1]);
      end
    end
    checks++;
    if (kv_cnt - kv0 !== 1 || {key_code, key_ext} !== {8'h74, 1'b1} ||
        cv_cnt - cv0 !== 1 || cmd !== 3'd1) begin
      errors++;
      $display("FAIL b2b_event got n=%0d %h/%b cmds=%0d cmd=%0d want 1 74/1 1 1",
               kv_cnt - kv0, key_code, key_ext, cv_cnt - cv0, cmd);
    end
    // trailing E0 is now pending; a reset must discard it and the held keys
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    settle(1);
    checks++;
    if (held !== 8'h00 || key_code !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_clear got held=%h code=%h want 00/00", held, key_code);
    end
    kv0 = kv_cnt; cv0 = cv_cnt;
    @(negedge clk);
    push_a(8'h74);
    settle(8);
    checks++;
    if (kv_cnt - kv0 !== 1 || {key_code, key_ext, key_brk} !== {8'h74, 1'b0, 1'b0} ||
        cv_cnt - cv0 !== 0 || held !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_ctx got n=%0d %h/%b/%b cmds=%0d held=%h want 1 74/0/0 0 00",
               kv_cnt - kv0, key_code, key_ext, key_brk, cv_cnt - cv0, held);
    end
    checks++;
    if (er_cnt - er0 !== 0) begin
      errors++;
      $display("FAIL rst_mid_err got %0d want 0", er_cnt - er0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_make();
    test_ext_make_break();
    test_repeat();
    test_pause_seq();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
